key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NUM_KEYS, 6, number of raw key inputs (1..15).
REQ-002 Parameter PRESCALE, 1023, clk_in cycles per tick (2..65535).
REQ-003 Parameter DEBOUNCE_TICKS, 64, consecutive stable ticks required to accept a press or a release (1..255).
REQ-004 Parameter REPEAT_DELAY, 32, ticks from press event to first repeat event (1..255).
REQ-005 Parameter REPEAT_RATE, 8, ticks between subsequent repeat events (1..255).
REQ-006 Derived constant CODE_W = clog2(NUM_KEYS+1).
REQ-007 clk_in  in  1  sole clock.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 keys_n  in  NUM_KEYS  raw asynchronous key inputs, active-low.
REQ-010 repeat_en  in  1  enables auto-repeat, sampled on ticks.
REQ-011 tick  out  1  one-cycle strobe every PRESCALE cycles.
REQ-012 key_valid  out  1  one-cycle event strobe.
REQ-013 key_code  out  CODE_W  event code, valid with key_valid; 0 otherwise.
REQ-014 key_repeat  out  1  high with key_valid when the event is a repeat.
REQ-015 key_held  out  1  level, high in PRESSED and REPEAT states.

Function
REQ-016 keys_n SHALL pass a 2-flop synchronizer per bit before use.
REQ-017 Synchronized keys SHALL be priority-encoded: lowest-index active key i gives code i+1; no key gives 0.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick SHALL be high in the cycle the count equals PRESCALE-1.
REQ-019 FSM state and counters SHALL change only in tick cycles, using the code sampled in that cycle.
REQ-020 IDLE: code nonzero -> latch candidate, db_cnt=1, go DEBOUNCE (if DEBOUNCE_TICKS=1, go PRESSED directly with press event).
REQ-021 DEBOUNCE: code equals candidate -> db_cnt+1; at db_cnt reaching DEBOUNCE_TICKS, emit press event and go PRESSED; code differs -> go IDLE, no event.
REQ-022 PRESSED: code differs from candidate -> go RELEASE, db_cnt=0; else rep_cnt+1, and when repeat_en=1 and rep_cnt reaches REPEAT_DELAY, emit repeat event, rep_cnt=0, go REPEAT.
REQ-023 REPEAT: code differs -> RELEASE; repeat_en=0 -> PRESSED with rep_cnt=0; else emit repeat event every REPEAT_RATE ticks.
REQ-024 RELEASE: code 0 -> db_cnt+1, go IDLE at DEBOUNCE_TICKS; code nonzero -> db_cnt=0, stay; no event is emitted for release.
REQ-025 A different key pressed while held SHALL NOT produce an event until full release and a new debounce.
REQ-026 Events SHALL be registered: key_valid, key_code and key_repeat are asserted in the cycle after the deciding tick, for exactly one cycle.
REQ-027 At most one event SHALL be emitted per tick; counters SHALL saturate and never wrap.

Reset
REQ-028 reset low SHALL asynchronously clear synchronizers, prescaler, counters, and FSM (to IDLE), and drive tick, key_valid, key_code, key_repeat and key_held to 0.
REQ-029 Reset asserted mid-debounce or mid-repeat SHALL discard the pending event; after release, the first tick occurs PRESCALE cycles later.

Structure
REQ-030 FSM state encoding (IDLE, DEBOUNCE, PRESSED, REPEAT, RELEASE) and the idle code 0 SHALL live in the shared key-codes package/header.
REQ-031 The prescaler SHALL be a separate sub-module, tick_gen, parametrised by PRESCALE.

Verification (NUM_KEYS=6, PRESCALE=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=8, REPEAT_RATE=2)
REQ-032 keys_n[2] held low 20 ticks, repeat_en=0 -> exactly one key_valid with key_code=3 and key_repeat=0, after the 3rd tick; key_held high until release debounced.
REQ-033 keys_n[0] low for 2 ticks, then high -> no key_valid; FSM returns to IDLE.
REQ-034 keys_n[4] held 20 ticks, repeat_en=1 -> press at tick 3, repeats (key_code=5, key_repeat=1) at ticks 11, 13, 15, 17, 19.
REQ-035 keys_n[1] and keys_n[3] low together -> single event with key_code=2; releasing key 1 alone while key 3 stays low -> no new event.
REQ-036 Release bounce: key 5 released with 1-tick glitches low every 2 ticks -> stays in RELEASE, no event, until 3 clean ticks.
REQ-037 reset pulsed low mid-DEBOUNCE -> all outputs 0 immediately; no event for that press.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: FSM states, the idle key code
// and the saturating counter helper.
package key_debounce_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_REPEAT,
        ST_RELEASE
    } state_t;

    localparam int unsigned CODE_IDLE = 0;
    localparam int          CNT_W     = 8;

    // Tick counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the final count as a
// one-cycle tick.
module tick_gen #(
    parameter int PRESCALE = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/key_debounce.sv
// Keypad debouncer: synchronises raw active-low keys, priority-encodes them and
// runs a tick-paced press/repeat/release FSM that emits one-cycle key events.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter  int NUM_KEYS       = 6,
    parameter  int PRESCALE       = 1023,
    parameter  int DEBOUNCE_TICKS = 64,
    parameter  int REPEAT_DELAY   = 32,
    parameter  int REPEAT_RATE    = 8,
    localparam int CODE_W         = $clog2(NUM_KEYS + 1)
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic                repeat_en,
    output logic                tick,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_repeat,
    output logic                key_held
);

    localparam logic [CNT_W-1:0]  DB_LIM   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0]  RD_LIM   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0]  RR_LIM   = CNT_W'(REPEAT_RATE);
    localparam logic [CODE_W-1:0] NO_CODE  = CODE_W'(CODE_IDLE);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [CODE_W-1:0]   w_code;
    logic                w_tick;
    logic [CNT_W-1:0]    w_db_inc;
    logic [CNT_W-1:0]    w_rep_inc;

    state_t              r_state;
    logic [CODE_W-1:0]   r_cand;
    logic [CNT_W-1:0]    r_db;
    logic [CNT_W-1:0]    r_rep;
    logic                r_valid;
    logic [CODE_W-1:0]   r_code;
    logic                r_repeat;
    logic                r_held;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .i_clk   (clk_in),
        .i_rst_n (reset),
        .o_tick  (w_tick)
    );

    // Keys are stored inverted so that a cleared synchroniser means "no key".
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~keys_n;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_code = NO_CODE;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (r_sync2[i]) begin
                w_code = CODE_W'(i + 1);
            end
        end
    end

    assign w_db_inc  = sat_inc(r_db);
    assign w_rep_inc = sat_inc(r_rep);

    // Event outputs default to zero every cycle so a tick's event lasts one cycle.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cand   <= NO_CODE;
            r_db     <= '0;
            r_rep    <= '0;
            r_valid  <= 1'b0;
            r_code   <= NO_CODE;
            r_repeat <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_code   <= NO_CODE;
            r_repeat <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_code != NO_CODE) begin
                            r_cand <= w_code;
                            r_db   <= CNT_W'(1);
                            r_rep  <= '0;
                            if (DB_LIM <= CNT_W'(1)) begin
                                r_state <= ST_PRESSED;
                                r_held  <= 1'b1;
                                r_valid <= 1'b1;
                                r_code  <= w_code;
                            end else begin
                                r_state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (w_code == r_cand) begin
                            r_db <= w_db_inc;
                            if (w_db_inc >= DB_LIM) begin
                                r_state <= ST_PRESSED;
                                r_held  <= 1'b1;
                                r_rep   <= '0;
                                r_valid <= 1'b1;
                                r_code  <= r_cand;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_code != r_cand) begin
                            r_state <= ST_RELEASE;
                            r_held  <= 1'b0;
                            r_db    <= '0;
                        end else if (repeat_en && (w_rep_inc >= RD_LIM)) begin
                            r_state  <= ST_REPEAT;
                            r_rep    <= '0;
                            r_valid  <= 1'b1;
                            r_code   <= r_cand;
                            r_repeat <= 1'b1;
                        end else begin
                            r_rep <= w_rep_inc;
                        end
                    end
                    ST_REPEAT: begin
                        if (w_code != r_cand) begin
                            r_state <= ST_RELEASE;
                            r_held  <= 1'b0;
                            r_db    <= '0;
                        end else if (!repeat_en) begin
                            r_state <= ST_PRESSED;
                            r_rep   <= '0;
                        end else if (w_rep_inc >= RR_LIM) begin
                            r_rep    <= '0;
                            r_valid  <= 1'b1;
                            r_code   <= r_cand;
                            r_repeat <= 1'b1;
                        end else begin
                            r_rep <= w_rep_inc;
                        end
                    end
                    ST_RELEASE: begin
                        // Any key seen here, even a different one, restarts the quiet count.
                        if (w_code == NO_CODE) begin
                            r_db <= w_db_inc;
                            if (w_db_inc >= DB_LIM) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_db <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tick       = w_tick;
    assign key_valid  = r_valid;
    assign key_code   = r_code;
    assign key_repeat = r_repeat;
    assign key_held   = r_held;

endmodule

// File: tb/tb_key_debounce.sv
// Randomised bench for key_debounce: a tick-level reference model pushes expected
// events into a queue that an independent monitor drains as the DUT emits them.
module tb_key_debounce;

    localparam int NUM_KEYS = 6;
    localparam int PRESCALE = 4;
    localparam int DT       = 3;
    localparam int RD       = 8;
    localparam int RR       = 2;
    localparam int CODE_W   = $clog2(NUM_KEYS + 1);

    typedef struct {
        int code;
        int rep;
        int tickIdx;
    } evt_t;

    logic                clk_in = 1'b0;
    logic                reset;
    logic [NUM_KEYS-1:0] keys_n;
    logic                repeat_en;
    logic                tick;
    logic                key_valid;
    logic [CODE_W-1:0]   key_code;
    logic                key_repeat;
    logic                key_held;

    int   compared = 0;
    int   failed   = 0;
    int   eventsSeen = 0;
    int   monTick  = 0;
    int   stimTick = 0;
    evt_t expQ[$];

    int   appliedMask = 0;
    bit   appliedRep  = 1'b0;

    int   mCand = 0, mStable = 0, mSince = 0, mQuiet = 0;
    bit   mArming = 0, mHeld = 0, mRepeating = 0, mReleasing = 0;

    key_debounce #(
        .NUM_KEYS       (NUM_KEYS),
        .PRESCALE       (PRESCALE),
        .DEBOUNCE_TICKS (DT),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .keys_n     (keys_n),
        .repeat_en  (repeat_en),
        .tick       (tick),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_repeat (key_repeat),
        .key_held   (key_held)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int codeOf(input int mask);
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (mask[i]) return i + 1;
        end
        return 0;
    endfunction

    // Behavioural reference: one call per tick, counting consecutive ticks of each condition.
    task automatic modelStep(input int code, input bit rep, output bit ev, output int evCode, output bit evRep);
        ev = 0; evCode = 0; evRep = 0;
        if (mReleasing) begin
            if (code == 0) begin
                mQuiet++;
                if (mQuiet >= DT) mReleasing = 0;
            end else begin
                mQuiet = 0;
            end
        end else if (mHeld) begin
            if (code != mCand) begin
                mHeld = 0; mRepeating = 0; mReleasing = 1; mQuiet = 0;
            end else if (mRepeating && !rep) begin
                mRepeating = 0; mSince = 0;
            end else begin
                mSince++;
                if (rep && mSince >= (mRepeating ? RR : RD)) begin
                    ev = 1; evCode = mCand; evRep = 1;
                    mSince = 0; mRepeating = 1;
                end
            end
        end else if (mArming) begin
            if (code == mCand) begin
                mStable++;
                if (mStable >= DT) begin
                    ev = 1; evCode = mCand;
                    mArming = 0; mHeld = 1; mSince = 0;
                end
            end else begin
                mArming = 0;
            end
        end else if (code != 0) begin
            mCand = code; mStable = 1; mSince = 0;
            if (DT <= 1) begin
                ev = 1; evCode = code; mHeld = 1;
            end else begin
                mArming = 1;
            end
        end
    endtask

    // One tick: model the tick with the inputs the DUT currently sees, then apply the next ones.
    task automatic applyStimulus(input int mask, input bit rep);
        bit   seen = 0;
        bit   ev;
        int   evCode;
        bit   evRep;
        evt_t e;
        for (int c = 0; c < 3 * PRESCALE && !seen; c++) begin
            @(negedge clk_in);
            if (tick) seen = 1;
        end
        if (!seen) checkOutput("tick_timeout", 0, 1);
        stimTick++;
        modelStep(codeOf(appliedMask), appliedRep, ev, evCode, evRep);
        if (ev) begin
            e.code = evCode; e.rep = int'(evRep); e.tickIdx = stimTick;
            expQ.push_back(e);
        end
        @(negedge clk_in);
        checkOutput("key_held", int'(key_held), int'(mHeld));
        keys_n      = ~NUM_KEYS'(mask);
        repeat_en   = rep;
        appliedMask = mask;
        appliedRep  = rep;
    endtask

    task automatic holdKeys(input int mask, input int n, input bit rep);
        for (int i = 0; i < n; i++) applyStimulus(mask, rep);
    endtask

    initial begin : monitor
        evt_t e;
        forever begin
            @(negedge clk_in);
            if (!reset) begin
                monTick = 0;
            end else begin
                if (key_valid) begin
                    eventsSeen++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_event", int'(key_code), 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("evt_code", int'(key_code), e.code);
                        checkOutput("evt_repeat", int'(key_repeat), e.rep);
                        checkOutput("evt_tick", monTick, e.tickIdx);
                    end
                end else begin
                    checkOutput("idle_outputs", int'({key_code, key_repeat}), 0);
                end
                if (tick) monTick++;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        failed++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int base;
        int edges;
        int mask;
        reset     = 1'b0;
        keys_n    = '1;
        repeat_en = 1'b0;
        #12;
        checkOutput("rst_tick", int'(tick), 0);
        checkOutput("rst_valid", int'(key_valid), 0);
        checkOutput("rst_code", int'(key_code), 0);
        checkOutput("rst_repeat", int'(key_repeat), 0);
        checkOutput("rst_held", int'(key_held), 0);
        @(negedge clk_in);
        reset = 1'b1;

        base = eventsSeen;
        holdKeys(1 << 2, 20, 1'b0);
        holdKeys(0, 6, 1'b0);
        @(negedge clk_in);
        checkOutput("single_press_events", eventsSeen - base, 1);

        base = eventsSeen;
        holdKeys(1 << 0, 2, 1'b0);
        holdKeys(0, 4, 1'b0);
        @(negedge clk_in);
        checkOutput("short_glitch_events", eventsSeen - base, 0);

        base = eventsSeen;
        holdKeys(1 << 4, 20, 1'b1);
        holdKeys(0, 6, 1'b1);
        @(negedge clk_in);
        checkOutput("repeat_events", eventsSeen - base, 6);

        base = eventsSeen;
        holdKeys(6'b001010, 6, 1'b0);
        holdKeys(6'b001000, 6, 1'b0);
        holdKeys(0, 6, 1'b0);
        @(negedge clk_in);
        checkOutput("two_key_events", eventsSeen - base, 1);

        base = eventsSeen;
        holdKeys(1 << 5, 6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0);
            applyStimulus(1 << 5, 1'b0);
        end
        holdKeys(0, 6, 1'b0);
        @(negedge clk_in);
        checkOutput("release_bounce_events", eventsSeen - base, 1);

        mask = 0;
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 19);
            bit rep = appliedRep;
            if (r == 17) mask = 0;
            else if (r == 18) mask = 1 << $urandom_range(0, NUM_KEYS - 1);
            else if (r == 19) mask = $urandom_range(0, (1 << NUM_KEYS) - 1);
            if ($urandom_range(0, 19) == 0) rep = ~rep;
            applyStimulus(mask, rep);
        end
        holdKeys(0, 8, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("queue_drained", expQ.size(), 0);

        holdKeys(1 << 3, 3, 1'b0);
        base = eventsSeen;
        reset  = 1'b0;
        keys_n = '1;
        #1;
        checkOutput("mid_rst_tick", int'(tick), 0);
        checkOutput("mid_rst_valid", int'(key_valid), 0);
        checkOutput("mid_rst_code", int'(key_code), 0);
        checkOutput("mid_rst_repeat", int'(key_repeat), 0);
        checkOutput("mid_rst_held", int'(key_held), 0);
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        edges = 0;
        for (int c = 0; c < 4 * PRESCALE; c++) begin
            @(posedge clk_in);
            edges++;
            #1;
            if (tick) break;
        end
        checkOutput("first_tick_edges", edges, PRESCALE - 1);
        repeat (6 * PRESCALE) @(negedge clk_in);
        checkOutput("reset_discard_events", eventsSeen - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
